// File: rtl/gfx_vram_arbiter_if.sv
// Bundle of CPU write-queue handshake and shared VRAM bus signals for gfx_vram_arbiter.
// slave  : arbiter side (consumes i_*, drives o_*)
// master : surrounding logic side (drives i_*, consumes o_*)
interface gfx_vram_arbiter_if;
   logic        i_cpu_req;
   logic [15:0] i_cpu_addr;
   logic [7:0]  i_cpu_data;
   logic        o_cpu_full;
   logic        o_cpu_empty;
   logic        i_free_vbus_b;
   logic [15:0] i_vga_vaddr;
   logic [15:0] o_vaddr;
   logic [7:0]  o_vdata;
   logic        o_vdata_oe;
   logic        o_vram_we_b;
   logic        o_vram1_ce_b;
   logic        o_vram2_ce_b;
   logic        o_bus_owned;

   modport slave (
      input  i_cpu_req, i_cpu_addr, i_cpu_data, i_free_vbus_b, i_vga_vaddr,
      output o_cpu_full, o_cpu_empty, o_vaddr, o_vdata, o_vdata_oe,
             o_vram_we_b, o_vram1_ce_b, o_vram2_ce_b, o_bus_owned
   );

   modport master (
      output i_cpu_req, i_cpu_addr, i_cpu_data, i_free_vbus_b, i_vga_vaddr,
      input  o_cpu_full, o_cpu_empty, o_vaddr, o_vdata, o_vdata_oe,
             o_vram_we_b, o_vram1_ce_b, o_vram2_ce_b, o_bus_owned
   );
endinterface

// File: rtl/gfx_vram_arbiter.sv
// VRAM bus arbiter: scanout owns the bus by default; queued CPU writes are
// played out (SETUP / WRITE x WrCycles / HOLD) only while i_free_vbus_b is low.
// Optional macro GFX_VRAM_ARB_DROP_CNT_EN adds an 8-bit saturating count of
// requests rejected because the queue was full (o_drop_cnt).
module gfx_vram_arbiter #(
   parameter int unsigned FifoDepth = 4,
   parameter int unsigned WrCycles  = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
`ifdef GFX_VRAM_ARB_DROP_CNT_EN
   output logic [7:0]        o_drop_cnt,
`endif
   gfx_vram_arbiter_if.slave vbus
);

   localparam int unsigned PTR_W = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned WC_W  = (WrCycles > 1) ? $clog2(WrCycles) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FifoDepth);
   localparam logic [WC_W-1:0]  WC_LOAD_C = WC_W'(WrCycles - 1);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WRITE, S_HOLD} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [15:0]      r_mem_addr [FifoDepth];
   logic [7:0]       r_mem_data [FifoDepth];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_nxt;
   logic             r_full;
   logic             r_empty;
   logic [WC_W-1:0]  r_wr_cnt;
   logic             w_push;
   logic             w_pop;
   logic             w_own;

   // Queue bookkeeping: full is the pre-edge value, so a push is refused even if a pop coincides
   always_comb begin
      w_push      = vbus.i_cpu_req & ~r_full;
      w_pop       = (r_state == S_HOLD) & ~vbus.i_free_vbus_b;
      w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
   end

   // Queue storage (no reset needed; contents are qualified by the count)
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem_addr[r_wptr] <= vbus.i_cpu_addr;
         r_mem_data[r_wptr] <= vbus.i_cpu_data;
      end
   end

   // Queue pointers, occupancy and registered full/empty flags
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == DEPTH_C);
         r_empty <= (w_count_nxt == '0);
      end
   end

   // FSM state register
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // WRITE-phase down-counter, loaded during SETUP
   always_ff @(posedge i_clk) begin
      if (i_rst)                                    r_wr_cnt <= '0;
      else if (r_state == S_SETUP)                  r_wr_cnt <= WC_LOAD_C;
      else if (r_state == S_WRITE && r_wr_cnt != '0) r_wr_cnt <= r_wr_cnt - 1'b1;
   end

   // FSM next-state: scanout reclaiming the bus aborts any phase without popping
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (r_count != '0 && !vbus.i_free_vbus_b) w_state_nxt = S_SETUP;
         end
         S_SETUP: begin
            w_state_nxt = vbus.i_free_vbus_b ? S_IDLE : S_WRITE;
         end
         S_WRITE: begin
            if (vbus.i_free_vbus_b)   w_state_nxt = S_IDLE;
            else if (r_wr_cnt == '0)  w_state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (!vbus.i_free_vbus_b && w_count_nxt != '0) w_state_nxt = S_SETUP;
            else                                          w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs: bus mux, strobes and chip enables decoded from the driven address
   always_comb begin
      w_own              = (r_state != S_IDLE);
      vbus.o_bus_owned   = w_own;
      vbus.o_vdata_oe    = w_own;
      vbus.o_vram_we_b   = (r_state != S_WRITE);
      vbus.o_vaddr       = w_own ? r_mem_addr[r_rptr] : vbus.i_vga_vaddr;
      vbus.o_vdata       = w_own ? r_mem_data[r_rptr] : '0;
      vbus.o_vram1_ce_b  = vbus.o_vaddr[15];
      vbus.o_vram2_ce_b  = ~vbus.o_vaddr[15];
      vbus.o_cpu_full    = r_full;
      vbus.o_cpu_empty   = r_empty;
   end

`ifdef GFX_VRAM_ARB_DROP_CNT_EN
   logic [7:0] r_drop_cnt;

   // Saturating count of requests refused while the queue was full
   always_ff @(posedge i_clk) begin
      if (i_rst)                                           r_drop_cnt <= '0;
      else if (vbus.i_cpu_req && r_full && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
   end

   assign o_drop_cnt = r_drop_cnt;
`else
   // Requests arriving while full are discarded silently.
`endif

endmodule

// File: doc/gfx_vram_arbiter.md
# gfx_vram_arbiter

Shares the VRAM bus between the scanout engine and CPU writes. The scanout engine owns the bus by default. Buffered CPU writes go into VRAM only while the scanout engine reports the bus free (`i_free_vbus_b` low). The block sits between the CPU-side gfx register decode, the `GfxVga` scanout core, and the two 32 KiB VRAM chips, and it drives the shared address, data and strobe lines.

## Interface
- `FifoDepth`, 4 — CPU write queue entries; power of two, minimum 2.
- `WrCycles`, 2 — cycles `o_vram_we_b` is held low per write; minimum 1.
- `i_clk` in 1 — pixel/system clock; all logic on its rising edge.
- `i_rst` in 1 — synchronous, active-high reset.
- `i_cpu_req` in 1 — one-cycle write request strobe.
- `i_cpu_addr` in 16 — VRAM byte address.
- `i_cpu_data` in 8 — write data.
- `o_cpu_full` out 1 — queue full; a request in this cycle is dropped.
- `o_cpu_empty` out 1 — queue empty and no write in progress.
- `i_free_vbus_b` in 1 — low: scanout is not using the bus.
- `i_vga_vaddr` in 16 — scanout read address.
- `o_vaddr` out 16 — VRAM address.
- `o_vdata` out 8 — VRAM write data, valid when `o_vdata_oe`=1.
- `o_vdata_oe` out 1 — enables the external data driver.
- `o_vram_we_b` out 1 — VRAM write strobe, active low.
- `o_vram1_ce_b` out 1 — equals `o_vaddr[15]`.
- `o_vram2_ce_b` out 1 — equals `~o_vaddr[15]`.
- `o_bus_owned` out 1 — high while the arbiter, not scanout, owns the bus.

## Operation
- FIFO of {addr, data}, `FifoDepth` deep, with registered read/write pointers and an occupancy count.
- Push: `i_cpu_req` && !`o_cpu_full`. A request while full is discarded.
- Push and pop in the same cycle is legal. `full` is the pre-edge value, so a push is rejected even if a pop happens in that cycle.
- FSM states, all transitions on a clock edge:
  - **IDLE**: scanout owns the bus. `o_vaddr`=`i_vga_vaddr`, `o_vdata_oe`=0, `o_vram_we_b`=1, `o_bus_owned`=0. Go to SETUP when the FIFO is non-empty and `i_free_vbus_b`=0.
  - **SETUP** (1 cycle): `o_vaddr`/`o_vdata` = FIFO head, `o_vdata_oe`=1, `o_vram_we_b`=1, `o_bus_owned`=1. Go to WRITE.
  - **WRITE** (`WrCycles` cycles, counted by a down-counter): head still driven, `o_vram_we_b`=0. Go to HOLD.
  - **HOLD** (1 cycle): head still driven, `o_vram_we_b`=1. Pop the head at the end of this cycle. Then:
    - go to SETUP if the FIFO still has entries after the pop and `i_free_vbus_b`=0;
    - otherwise go to IDLE.
- Preemption: if `i_free_vbus_b` samples 1 in SETUP, WRITE or HOLD, go to IDLE on the next edge without popping.
  - `o_vram_we_b` returns to 1 on that edge.
  - The entry is retried in full later. VRAM writes are idempotent, so a retry is harmless.
- Chip enables are always decoded from `o_vaddr[15]`, in every state.

## Timing
- Reset values:
  - state IDLE, FIFO empty, counters 0;
  - `o_cpu_full`=0, `o_cpu_empty`=1, `o_vram_we_b`=1, `o_vdata_oe`=0, `o_bus_owned`=0;
  - `o_vdata`=0, `o_vaddr`=`i_vga_vaddr`.
- Reset mid-write: `o_vram_we_b` is 1 after the reset edge, and queued writes are lost.
- Latency:
  - A request sampled at edge k is in the FIFO after edge k.
  - SETUP starts at edge k+1 if the bus is free then.
  - `o_vram_we_b` falls at edge k+2.
- One write occupies `WrCycles`+2 cycles; the default is 4.
- Back-to-back writes go HOLD→SETUP with no IDLE gap.
- `o_vaddr` and `o_vdata` are stable from the start of SETUP to the end of HOLD. This gives one cycle of address/data setup and one of hold around the `o_vram_we_b` pulse.
- `o_cpu_full`/`o_cpu_empty` are registered and update on the same edge as the push or pop.

## Configuration
- `GFX_VRAM_ARB_DROP_CNT_EN` defined:
  - adds output `o_drop_cnt` (out, 8 bits), reset 0;
  - increments on every rejected request and saturates at 255;
  - clears on `i_rst` only.
- Not defined: the port and counter are absent, and dropped requests are silent.

## Test plan
- Bus free, one request (addr 16'h8123, data 8'hA5):
  - SETUP at k+1, `o_vram_we_b` low for 2 cycles from k+2;
  - `o_vram2_ce_b`=0, `o_vram1_ce_b`=1;
  - `o_cpu_empty` back to 1 after HOLD.
- Bus busy (`i_free_vbus_b`=1), then 4 requests: `o_cpu_full`=1 after the 4th. On release, 4 back-to-back writes of 4 cycles each with no IDLE gap; addresses appear in FIFO order.
- `i_free_vbus_b` rises during the 1st WRITE cycle: `o_vram_we_b` is 1 and `o_vaddr`=`i_vga_vaddr` after the next edge, and no pop occurs. On release the same entry is written in full.
- 5th request while full and the macro defined: request dropped, `o_drop_cnt`=1. After 300 drops, `o_drop_cnt` holds at 255.
- `i_rst` asserted during WRITE with 3 entries queued: after the edge, `o_vram_we_b`=1, `o_cpu_empty`=1, `o_bus_owned`=0, and no further writes occur.
- Push and pop in the same cycle with the FIFO at 3 of 4 entries: the push is accepted and the occupancy stays at 3.
